// File: rtl/sync_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_down_counter                                             |
// | Description : Loadable synchronous down-counter / interval timer. A loaded  |
// |               value counts down to zero on enabled cycles. Expiry raises a  |
// |               one-cycle done pulse. tc flags q == 0 combinationally.        |
// |               Optional macro AUTO_RELOAD_EN: at expiry, reload q from the   |
// |               reload register and keep running (periodic timer).            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_nxt;
  logic             done_r;
  logic             done_nxt;

  // State register together with the count, reload value and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= C_ZERO;
      rld    <= C_ZERO;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rld    <= rld_nxt;
      done_r <= done_nxt;
    end
  end

  // Next-state and datapath: load beats abort, abort beats counting.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rld_nxt   = rld;
    done_nxt  = 1'b0;
    if (load) begin
      count_nxt = load_val;
      rld_nxt   = load_val;
      state_nxt = (load_val != C_ZERO) ? S_RUN : S_IDLE;
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else if (state == S_RUN) begin
      if (count == C_ZERO) begin
        // Unreachable in normal operation; never wrap below zero.
        state_nxt = S_IDLE;
      end else if (en) begin
        if (count > C_ONE) begin
          count_nxt = count - C_ONE;
        end else begin
          // Expiry: count is 1 and an enabled cycle arrives.
          done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
          count_nxt = rld;
          state_nxt = S_RUN;
`else
          count_nxt = C_ZERO;
          state_nxt = S_IDLE;
`endif
        end
      end
    end
  end

  // Outputs: busy and done come straight from registers, tc decodes the count.
  always_comb begin
    q    = count;
    busy = (state == S_RUN);
    done = done_r;
    tc   = (count == C_ZERO);
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_down_counter                                          |
// | Description : Self-checking bench for sync_down_counter (WIDTH=4). A        |
// |               behavioural model is compared every cycle, and directed       |
// |               vectors carry hand-computed literal expectations.             |
// |               Honours AUTO_RELOAD_EN when the design is built with it.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             tc;

  int errors = 0;
  int checks = 0;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the timer's rules written as plain arithmetic.
  int m_q = 0;
  int m_rld = 0;
  bit m_run = 0;
  bit m_done = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q = 0; m_rld = 0; m_run = 0; m_done = 0; m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (load) begin
        m_q = int'(load_val); m_rld = int'(load_val); m_run = (load_val != 0);
      end else if (abort) begin
        m_run = 0;
      end else if (m_run && en) begin
        if (m_q == 1) begin
          m_done = 1;
`ifdef AUTO_RELOAD_EN
          m_q = m_rld;
`else
          m_q = 0;
          m_run = 0;
`endif
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q",    int'(q),    m_q);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_done));
      chk("model_tc",   int'(tc),   int'(m_q == 0));
    end
  end

  // Apply one cycle of inputs and return once the outputs reflect it.
  task automatic cyc(input bit r, input bit ld, input int lv, input bit e, input bit ab);
    rst = r; load = ld; load_val = WIDTH'(lv); en = e; abort = ab;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int eq, input int eb, input int ed);
    chk({name, "_q"},    int'(q),    eq);
    chk({name, "_busy"}, int'(busy), eb);
    chk({name, "_done"}, int'(done), ed);
    chk({name, "_tc"},   int'(tc),   int'(eq == 0));
  endtask

  initial begin
    int exp_q [5];
    int exp_d [5];
    @(negedge clk);
    // 1: reset for two edges
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0);

`ifdef AUTO_RELOAD_EN
    // 6: periodic reload with period 3
    cyc(0, 1, 3, 0, 0);
    expect_out("ar_load", 3, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 0);
      case (i % 3)
        0: expect_out("ar_step", 2, 1, 0);
        1: expect_out("ar_step", 1, 1, 0);
        default: expect_out("ar_step", 3, 1, 1);
      endcase
    end
    cyc(0, 0, 0, 0, 1);
    expect_out("ar_abort", 3, 0, 0);
`else
    // 2: load 5, count to zero with en held high
    cyc(0, 1, 5, 1, 0);
    expect_out("t2_load", 5, 1, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_4", 4, 1, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_3", 3, 1, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_2", 2, 1, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_1", 1, 1, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_exp", 0, 0, 1);
    cyc(0, 0, 0, 1, 0); expect_out("t2_idle", 0, 0, 0);
    cyc(0, 0, 0, 1, 0); expect_out("t2_nowrap", 0, 0, 0);

    // 3: load 3 with en toggling
    cyc(0, 1, 3, 0, 0);
    expect_out("t3_load", 3, 1, 0);
    exp_q = '{2, 2, 1, 1, 0};
    exp_d = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, (i % 2) == 0, 0);
      expect_out("t3_step", exp_q[i], (i < 4) ? 1 : 0, exp_d[i]);
    end

    // 4: abort at 9, then load 0
    cyc(0, 1, 15, 1, 0);
    expect_out("t4_load", 15, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    expect_out("t4_at9", 9, 1, 0);
    cyc(0, 0, 0, 1, 1);
    expect_out("t4_abort", 9, 0, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("t4_idle_en", 9, 0, 0);
    cyc(0, 1, 0, 1, 0);
    expect_out("t4_load0", 0, 0, 0);

    // 5: load overrides expiry; reset mid-count
    cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("t5_at1", 1, 1, 0);
    cyc(0, 1, 7, 1, 0);
    expect_out("t5_ldexp", 7, 1, 0);
    cyc(0, 0, 0, 1, 0);
    expect_out("t5_at6", 6, 1, 0);
    cyc(1, 0, 0, 1, 0);
    expect_out("t5_rst", 0, 0, 0);

    // abort coinciding with expiry suppresses done
    cyc(0, 1, 1, 0, 0);
    expect_out("ab_load1", 1, 1, 0);
    cyc(0, 0, 0, 1, 1);
    expect_out("ab_exp", 1, 0, 0);

    // load of zero while running stops without a pulse
    cyc(0, 1, 4, 0, 0);
    cyc(0, 1, 0, 1, 0);
    expect_out("run_load0", 0, 0, 0);
`endif

    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
